// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard controller: FSM encoding, the zero
// register and the opcodes the upstream decoder maps onto id_is_branch/ex_is_load.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LSTALL = 2'd1,
    BSTALL = 2'd2
  } hz_state_e;

  localparam int unsigned REG_ZERO = 0;

  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_ctr_fwd_mux.sv
// Single-operand forwarding mux: youngest producer wins (EX, MEM, WB), else
// the register-file read value.
module fwd_mux
  import hazard_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              ex_wreg,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              mem_wreg,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_wreg,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] fwd_data
);

  logic ex_hit_s;
  logic mem_hit_s;
  logic wb_hit_s;

  // A load's EX result is only an address, so it never forwards from EX.
  always_comb begin
    ex_hit_s  = ex_wreg && !ex_is_load && (ex_dest != REG_AW'(REG_ZERO)) && (ex_dest == src);
    mem_hit_s = mem_wreg && (mem_dest != REG_AW'(REG_ZERO)) && (mem_dest == src);
    wb_hit_s  = wb_wreg && (wb_dest != REG_AW'(REG_ZERO)) && (wb_dest == src);
    if (ex_hit_s) begin
      fwd_data = ex_data;
    end else if (mem_hit_s) begin
      fwd_data = mem_data;
    end else if (wb_hit_s) begin
      fwd_data = wb_data;
    end else begin
      fwd_data = rf_data;
    end
  end

endmodule

// File: rtl/hazard_ctr.sv
// Hazard controller: ID-stage operand forwarding plus counter-driven load-use
// and branch stall sequencing, with a saturating stall-cycle counter.
module hazard_ctr
  import hazard_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int REG_AW         = 5,
  parameter int LOAD_STALL_CYC = 1,
  parameter int BR_STALL_CYC   = 2,
  parameter int CNT_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_is_branch,
  input  logic [DATA_W-1:0] id_inA,
  input  logic [DATA_W-1:0] id_inB,
  input  logic              ex_wreg,
  input  logic              mem_wreg,
  input  logic              wb_wreg,
  input  logic [REG_AW-1:0] ex_destR,
  input  logic [REG_AW-1:0] mem_destR,
  input  logic [REG_AW-1:0] wb_destR,
  input  logic              ex_is_load,
  input  logic [DATA_W-1:0] ex_aluR,
  input  logic [DATA_W-1:0] mem_aluR,
  input  logic [DATA_W-1:0] wb_dest,
  input  logic              br_resolved,
  output logic [DATA_W-1:0] id_inA_forward,
  output logic [DATA_W-1:0] id_inB_forward,
  output logic              stall_if,
  output logic              stall_id,
  output logic              bubble_ex,
  output logic              flush_id,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int MAX_STALL = int'(max2(LOAD_STALL_CYC, BR_STALL_CYC));
  localparam int CW        = $clog2(MAX_STALL + 1);

  hz_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              lu_s;
  logic              br_s;

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_a (
    .src(id_rs), .rf_data(id_inA),
    .ex_wreg(ex_wreg), .ex_is_load(ex_is_load), .ex_dest(ex_destR), .ex_data(ex_aluR),
    .mem_wreg(mem_wreg), .mem_dest(mem_destR), .mem_data(mem_aluR),
    .wb_wreg(wb_wreg), .wb_dest(wb_destR), .wb_data(wb_dest),
    .fwd_data(id_inA_forward)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_b (
    .src(id_rt), .rf_data(id_inB),
    .ex_wreg(ex_wreg), .ex_is_load(ex_is_load), .ex_dest(ex_destR), .ex_data(ex_aluR),
    .mem_wreg(mem_wreg), .mem_dest(mem_destR), .mem_data(mem_aluR),
    .wb_wreg(wb_wreg), .wb_dest(wb_destR), .wb_data(wb_dest),
    .fwd_data(id_inB_forward)
  );

  // Hazard detection; a load-use stall takes precedence over a branch in ID.
  always_comb begin
    lu_s = id_valid && ex_is_load && ex_wreg && (ex_destR != REG_AW'(REG_ZERO)) &&
           ((id_use_rs && (ex_destR == id_rs)) || (id_use_rt && (ex_destR == id_rt)));
    br_s = id_valid && id_is_branch && !lu_s;
  end

  // Next-state and stall outputs; cnt holds the stall cycles still to come.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    case (state_q)
      IDLE: begin
        if (lu_s) begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          bubble_ex = 1'b1;
          if (LOAD_STALL_CYC > 1) begin
            state_d = LSTALL;
            cnt_d   = CW'(LOAD_STALL_CYC - 1);
          end else begin
            state_d = IDLE;
          end
        end else if (br_s) begin
          stall_if = 1'b1;
          flush_id = 1'b1;
          if (BR_STALL_CYC > 1) begin
            state_d = BSTALL;
            cnt_d   = CW'(BR_STALL_CYC - 1);
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LSTALL: begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
        cnt_d     = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
        end else begin
          state_d = LSTALL;
        end
      end
      BSTALL: begin
        stall_if = 1'b1;
        flush_id = 1'b1;
        cnt_d    = cnt_q - CW'(1);
        if ((cnt_q == CW'(1)) || br_resolved) begin
          state_d = IDLE;
          cnt_d   = CW'(0);
        end else begin
          state_d = BSTALL;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CW'(0);
      end
    endcase

    if (rst) begin
      state_d   = IDLE;
      cnt_d     = CW'(0);
      stall_if  = 1'b0;
      stall_id  = 1'b0;
      bubble_ex = 1'b0;
      flush_id  = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  // Saturating count of fetch-stall cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (rst) begin
      stall_cnt_d = {CNT_W{1'b0}};
    end else if (stall_if && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    state_q     <= state_d;
    cnt_q       <= cnt_d;
    stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctr.sv
// Bench for hazard_ctr: two configurations (default, and LOAD=3/BR=4/CNT_W=4)
// share stimulus and are checked against a remaining-cycles reference model.
module tb_hazard_ctr;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_use_rs, id_use_rt, id_is_branch;
  logic [4:0]  id_rs, id_rt;
  logic [31:0] id_inA, id_inB;
  logic        ex_wreg, mem_wreg, wb_wreg, ex_is_load, br_resolved;
  logic [4:0]  ex_destR, mem_destR, wb_destR;
  logic [31:0] ex_aluR, mem_aluR, wb_dest;

  logic [31:0] fa_a, fb_a, fa_b, fb_b;
  logic        sif_a, sid_a, bub_a, fl_a;
  logic        sif_b, sid_b, bub_b, fl_b;
  logic [31:0] scnt_a;
  logic [3:0]  scnt_b;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state, index 0 = dut_a, 1 = dut_b
  int     lcyc[2] = '{1, 3};
  int     bcyc[2] = '{2, 4};
  longint cmax[2] = '{64'hFFFF_FFFF, 64'd15};
  int     rem[2];
  int     kind[2];
  int     mode[2];
  longint mscnt[2];
  logic   m_lu, m_br;
  logic [31:0] e_fa, e_fb;

  always #5 clk = ~clk;

  hazard_ctr dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_is_branch(id_is_branch),
    .id_inA(id_inA), .id_inB(id_inB), .ex_wreg(ex_wreg), .mem_wreg(mem_wreg),
    .wb_wreg(wb_wreg), .ex_destR(ex_destR), .mem_destR(mem_destR), .wb_destR(wb_destR),
    .ex_is_load(ex_is_load), .ex_aluR(ex_aluR), .mem_aluR(mem_aluR), .wb_dest(wb_dest),
    .br_resolved(br_resolved), .id_inA_forward(fa_a), .id_inB_forward(fb_a),
    .stall_if(sif_a), .stall_id(sid_a), .bubble_ex(bub_a), .flush_id(fl_a),
    .stall_cnt(scnt_a)
  );

  hazard_ctr #(.LOAD_STALL_CYC(3), .BR_STALL_CYC(4), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_is_branch(id_is_branch),
    .id_inA(id_inA), .id_inB(id_inB), .ex_wreg(ex_wreg), .mem_wreg(mem_wreg),
    .wb_wreg(wb_wreg), .ex_destR(ex_destR), .mem_destR(mem_destR), .wb_destR(wb_destR),
    .ex_is_load(ex_is_load), .ex_aluR(ex_aluR), .mem_aluR(mem_aluR), .wb_dest(wb_dest),
    .br_resolved(br_resolved), .id_inA_forward(fa_b), .id_inB_forward(fb_b),
    .stall_if(sif_b), .stall_id(sid_b), .bubble_ex(bub_b), .flush_id(fl_b),
    .stall_cnt(scnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_fwd(input logic [4:0] src, input logic [31:0] rf);
    if (ex_wreg && !ex_is_load && ex_destR != 5'd0 && ex_destR == src) return ex_aluR;
    if (mem_wreg && mem_destR != 5'd0 && mem_destR == src) return mem_aluR;
    if (wb_wreg && wb_destR != 5'd0 && wb_destR == src) return wb_dest;
    return rf;
  endfunction

  // mode: 0 no stall, 1 load stall cycle, 2 branch stall cycle
  task automatic model_eval();
    m_lu = id_valid && ex_is_load && ex_wreg && (ex_destR != 5'd0) &&
           ((id_use_rs && ex_destR == id_rs) || (id_use_rt && ex_destR == id_rt));
    m_br = id_valid && id_is_branch && !m_lu;
    e_fa = ref_fwd(id_rs, id_inA);
    e_fb = ref_fwd(id_rt, id_inB);
    for (int i = 0; i < 2; i++) begin
      if (rst) mode[i] = 0;
      else if (rem[i] > 0) mode[i] = kind[i];
      else if (m_lu) mode[i] = 1;
      else if (m_br) mode[i] = 2;
      else mode[i] = 0;
    end
  endtask

  task automatic model_adv();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        rem[i] = 0;
        mscnt[i] = 0;
      end else begin
        if (mode[i] != 0 && mscnt[i] < cmax[i]) mscnt[i] = mscnt[i] + 1;
        if (rem[i] > 0) begin
          if (kind[i] == 2 && br_resolved) rem[i] = 0;
          else rem[i] = rem[i] - 1;
        end else if (m_lu) begin
          rem[i] = lcyc[i] - 1; kind[i] = 1;
        end else if (m_br) begin
          rem[i] = bcyc[i] - 1; kind[i] = 2;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_eval();
    chk("a.fwdA", fa_a, e_fa);
    chk("a.fwdB", fb_a, e_fb);
    chk("b.fwdA", fa_b, e_fa);
    chk("b.fwdB", fb_b, e_fb);
    chk("a.stall_if", 32'(sif_a), 32'(mode[0] != 0));
    chk("a.stall_id", 32'(sid_a), 32'(mode[0] == 1));
    chk("a.bubble_ex", 32'(bub_a), 32'(mode[0] == 1));
    chk("a.flush_id", 32'(fl_a), 32'(mode[0] == 2));
    chk("a.stall_cnt", scnt_a, 32'(mscnt[0]));
    chk("b.stall_if", 32'(sif_b), 32'(mode[1] != 0));
    chk("b.stall_id", 32'(sid_b), 32'(mode[1] == 1));
    chk("b.bubble_ex", 32'(bub_b), 32'(mode[1] == 1));
    chk("b.flush_id", 32'(fl_b), 32'(mode[1] == 2));
    chk("b.stall_cnt", 32'(scnt_b), 32'(mscnt[1]));
    model_adv();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    rst = 1'b0; id_valid = 1'b0; id_use_rs = 1'b0; id_use_rt = 1'b0; id_is_branch = 1'b0;
    id_rs = 5'd0; id_rt = 5'd0; id_inA = $urandom; id_inB = $urandom;
    ex_wreg = 1'b0; mem_wreg = 1'b0; wb_wreg = 1'b0; ex_is_load = 1'b0; br_resolved = 1'b0;
    ex_destR = 5'd0; mem_destR = 5'd0; wb_destR = 5'd0;
    ex_aluR = $urandom; mem_aluR = $urandom; wb_dest = $urandom;
  endtask

  task automatic do_reset();
    clear();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    clear();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      rem[i] = 0; kind[i] = 0; mode[i] = 0; mscnt[i] = 0;
    end
    do_reset();
    chk("reset.stall_cnt_a", scnt_a, 32'd0);

    // forwarding priority
    ex_wreg = 1'b1; mem_wreg = 1'b1; wb_wreg = 1'b1;
    ex_destR = 5'd5; mem_destR = 5'd5; wb_destR = 5'd5;
    ex_aluR = 32'h11; mem_aluR = 32'h22; wb_dest = 32'h33;
    id_rs = 5'd5; id_rt = 5'd5;
    #1 chk("fwd.ex", fa_a, 32'h11);
    step();
    ex_wreg = 1'b0;
    #1 chk("fwd.mem", fa_a, 32'h22);
    step();
    mem_destR = 5'd0;
    #1 chk("fwd.wb", fb_a, 32'h33);
    step();
    id_rs = 5'd0; wb_destR = 5'd0; id_inA = 32'hCAFE_0000;
    #1 chk("fwd.r0", fa_a, 32'hCAFE_0000);
    step();

    // load-use via rt
    do_reset();
    ex_is_load = 1'b1; ex_wreg = 1'b1; ex_destR = 5'd3;
    id_valid = 1'b1; id_use_rt = 1'b1; id_rt = 5'd3;
    #1 chk("lu.bubble_a", 32'(bub_a), 32'd1);
    step();
    ex_is_load = 1'b0; ex_wreg = 1'b0;
    repeat (4) step();
    chk("lu.stall_cnt_a", scnt_a, 32'd1);
    chk("lu.stall_cnt_b", 32'(scnt_b), 32'd3);
    ex_is_load = 1'b1; ex_wreg = 1'b1; id_use_rt = 1'b0;
    #1 chk("lu.no_use", 32'(sif_a), 32'd0);
    step();

    // branch, full length
    do_reset();
    id_valid = 1'b1; id_is_branch = 1'b1;
    step();
    id_is_branch = 1'b0;
    repeat (5) step();
    chk("br.full_cnt_b", 32'(scnt_b), 32'd4);
    chk("br.full_cnt_a", scnt_a, 32'd2);

    // branch resolved in its second cycle
    do_reset();
    id_valid = 1'b1; id_is_branch = 1'b1;
    step();
    id_is_branch = 1'b0; br_resolved = 1'b1;
    step();
    br_resolved = 1'b0;
    #1 chk("br.early_off", 32'(sif_b), 32'd0);
    repeat (3) step();
    chk("br.early_cnt_b", 32'(scnt_b), 32'd2);

    // load-use and branch together
    do_reset();
    ex_is_load = 1'b1; ex_wreg = 1'b1; ex_destR = 5'd4;
    id_valid = 1'b1; id_is_branch = 1'b1; id_use_rs = 1'b1; id_rs = 5'd4;
    #1 chk("both.flush_a0", 32'(fl_a), 32'd0);
    step();
    ex_is_load = 1'b0; ex_wreg = 1'b0;
    #1 chk("both.flush_a1", 32'(fl_a), 32'd1);
    step();
    id_is_branch = 1'b0;
    repeat (8) step();

    // reset in the middle of a branch stall
    do_reset();
    id_valid = 1'b1; id_is_branch = 1'b1;
    step();
    id_is_branch = 1'b0; rst = 1'b1;
    #1 chk("rst.mid_if_b", 32'(sif_b), 32'd0);
    step();
    rst = 1'b0;
    repeat (2) step();
    chk("rst.cnt_b", 32'(scnt_b), 32'd0);

    // saturation of the 4-bit counter
    do_reset();
    id_valid = 1'b1; id_is_branch = 1'b1;
    repeat (20) step();
    chk("sat.cnt_b", 32'(scnt_b), 32'd15);
    chk("sat.cnt_a", scnt_a, 32'd20);

    // randomized traffic
    do_reset();
    for (int n = 0; n < 500; n++) begin
      rst          = ($urandom_range(0, 39) == 0);
      id_valid     = ($urandom_range(0, 3) != 0);
      id_use_rs    = $urandom_range(0, 1);
      id_use_rt    = $urandom_range(0, 1);
      id_is_branch = ($urandom_range(0, 3) == 0);
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      ex_destR     = 5'($urandom_range(0, 3));
      mem_destR    = 5'($urandom_range(0, 3));
      wb_destR     = 5'($urandom_range(0, 3));
      ex_wreg      = $urandom_range(0, 1);
      mem_wreg     = $urandom_range(0, 1);
      wb_wreg      = $urandom_range(0, 1);
      ex_is_load   = ($urandom_range(0, 2) == 0);
      br_resolved  = ($urandom_range(0, 3) == 0);
      id_inA = $urandom; id_inB = $urandom;
      ex_aluR = $urandom; mem_aluR = $urandom; wb_dest = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
